// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: op-vector bit indices, opcodes and funct codes.
package mips_pkg;

  localparam int OP_W = 31;

  // Bit positions in the one-hot op vector consumed by Control
  localparam int OP_ADDU  = 0;
  localparam int OP_ADD   = 1;
  localparam int OP_SUBU  = 2;
  localparam int OP_SUB   = 3;
  localparam int OP_AND   = 4;
  localparam int OP_OR    = 5;
  localparam int OP_XOR   = 6;
  localparam int OP_NOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_SLT   = 11;
  localparam int OP_SLTU  = 12;
  localparam int OP_SLLV  = 13;
  localparam int OP_SRLV  = 14;
  localparam int OP_SRAV  = 15;
  localparam int OP_ADDI  = 16;
  localparam int OP_ADDIU = 17;
  localparam int OP_ANDI  = 18;
  localparam int OP_ORI   = 19;
  localparam int OP_XORI  = 20;
  localparam int OP_SLTI  = 21;
  localparam int OP_SLTIU = 22;
  localparam int OP_LUI   = 23;
  localparam int OP_LW    = 24;
  localparam int OP_SW    = 25;
  localparam int OP_BEQ   = 26;
  localparam int OP_BNE   = 27;
  localparam int OP_J     = 28;
  localparam int OP_JAL   = 29;
  localparam int OP_JR    = 30;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/instr_decode_rom.sv
// Combinational instruction classifier: one-hot op, illegal flag and
// zero-extend select for the immediate.
module instr_decode_rom
  import mips_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [OP_W-1:0] op,
  output logic            illegal,
  output logic            zext
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  // rs/rt/rd/shamt take no part in classification
  assign unused_fields = ^instr[25:6];

  // Match opcode (and funct for R-type); anything unmatched is illegal with op=0
  always_comb begin
    op      = '0;
    illegal = 1'b0;
    zext    = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADDU: op[OP_ADDU] = 1'b1;
          FN_ADD:  op[OP_ADD]  = 1'b1;
          FN_SUBU: op[OP_SUBU] = 1'b1;
          FN_SUB:  op[OP_SUB]  = 1'b1;
          FN_AND:  op[OP_AND]  = 1'b1;
          FN_OR:   op[OP_OR]   = 1'b1;
          FN_XOR:  op[OP_XOR]  = 1'b1;
          FN_NOR:  op[OP_NOR]  = 1'b1;
          FN_SLL:  op[OP_SLL]  = 1'b1;
          FN_SRL:  op[OP_SRL]  = 1'b1;
          FN_SRA:  op[OP_SRA]  = 1'b1;
          FN_SLT:  op[OP_SLT]  = 1'b1;
          FN_SLTU: op[OP_SLTU] = 1'b1;
          FN_SLLV: op[OP_SLLV] = 1'b1;
          FN_SRLV: op[OP_SRLV] = 1'b1;
          FN_SRAV: op[OP_SRAV] = 1'b1;
          FN_JR:   op[OP_JR]   = 1'b1;
          default: illegal     = 1'b1;
        endcase
      end
      OPC_ADDI:  op[OP_ADDI]  = 1'b1;
      OPC_ADDIU: op[OP_ADDIU] = 1'b1;
      OPC_ANDI: begin
        op[OP_ANDI] = 1'b1;
        zext        = 1'b1;
      end
      OPC_ORI: begin
        op[OP_ORI] = 1'b1;
        zext       = 1'b1;
      end
      OPC_XORI: begin
        op[OP_XORI] = 1'b1;
        zext        = 1'b1;
      end
      OPC_SLTI:  op[OP_SLTI]  = 1'b1;
      OPC_SLTIU: op[OP_SLTIU] = 1'b1;
      OPC_LUI:   op[OP_LUI]   = 1'b1;
      OPC_LW:    op[OP_LW]    = 1'b1;
      OPC_SW:    op[OP_SW]    = 1'b1;
      OPC_BEQ:   op[OP_BEQ]   = 1'b1;
      OPC_BNE:   op[OP_BNE]   = 1'b1;
      OPC_J:     op[OP_J]     = 1'b1;
      OPC_JAL:   op[OP_JAL]   = 1'b1;
      default:   illegal      = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: one-slot valid/ready buffer holding the decoded
// instruction, with branch flush and a saturating illegal-instruction counter.
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      op,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [4:0]           shamt,
  output logic [31:0]          imm_ext,
  output logic [25:0]          target,
  output logic [31:0]          out_pc,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] illegal_cnt
);

  localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  logic [OP_W-1:0] dec_op;
  logic            dec_illegal;
  logic            dec_zext;
  logic            load;
  logic [31:0]     dec_imm;

  instr_decode_rom u_rom (
    .instr   (in_instr),
    .op      (dec_op),
    .illegal (dec_illegal),
    .zext    (dec_zext)
  );

  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready & ~flush;
  assign dec_imm  = dec_zext ? {16'h0000, in_instr[15:0]}
                             : {{16{in_instr[15]}}, in_instr[15:0]};

  // Storage slot: flush empties it, a load refills it, a consume without load
  // empties it; op/illegal are cleared whenever the slot goes empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      shamt     <= '0;
      imm_ext   <= '0;
      target    <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      op        <= dec_op;
      illegal   <= dec_illegal;
      rs        <= in_instr[25:21];
      rt        <= in_instr[20:16];
      rd        <= in_instr[15:11];
      shamt     <= in_instr[10:6];
      imm_ext   <= dec_imm;
      target    <= in_instr[25:0];
      out_pc    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
    end
  end

  // Count accepted illegal instructions, sticking at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (load && dec_illegal && !(&illegal_cnt)) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: table-driven reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [30:0] op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext;
  logic [25:0] target;
  logic [31:0] out_pc;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [30:0] op2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [31:0] imm_ext2;
  logic [25:0] target2;
  logic [31:0] out_pc2;
  logic        illegal2;
  logic [1:0]  illegal_cnt2;

  int n_compared;
  int n_mismatched;

  instr_decode_stage #(.ILL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm_ext(imm_ext), .target(target), .out_pc(out_pc), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  instr_decode_stage #(.ILL_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .op(op2), .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2),
    .imm_ext(imm_ext2), .target(target2), .out_pc(out_pc2), .illegal(illegal2),
    .illegal_cnt(illegal_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode tables: position in the table is the op bit
  localparam logic [5:0] R_FUNCT [0:15] = '{6'h21, 6'h20, 6'h23, 6'h22, 6'h24, 6'h25,
                                            6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2A,
                                            6'h2B, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] I_OPC [0:13] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                                          6'h0B, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05,
                                          6'h02, 6'h03};

  function automatic int model_bit(input logic [31:0] w);
    int b;
    b = -1;
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 16; i++)
        if (w[5:0] == R_FUNCT[i]) b = i;
      if (w[5:0] == 6'h08) b = 30;
    end else begin
      for (int i = 0; i < 14; i++)
        if (w[31:26] == I_OPC[i]) b = 16 + i;
    end
    return b;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    int b;
    b = model_bit(w);
    if (b == 18 || b == 19 || b == 20) return {16'h0000, w[15:0]};
    return {{16{w[15]}}, w[15:0]};
  endfunction

  // Model state: slot occupancy, held word and PC, and the two counters
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  int          m_cnt8;
  int          m_cnt2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_instr <= 32'h0;
      m_pc    <= 32'h0;
      m_cnt8  <= 0;
      m_cnt2  <= 0;
    end else begin
      if (flush) begin
        m_valid <= 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_instr <= in_instr;
        m_pc    <= in_pc;
        if (model_bit(in_instr) < 0) begin
          m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare both DUTs against the model away from the rising edge
  always @(negedge clk) begin
    logic [30:0] e_op;
    int          b;
    if (rst_n) begin
      b    = model_bit(m_instr);
      e_op = (m_valid && b >= 0) ? (31'd1 << b) : 31'd0;
      checkOutput("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      checkOutput("cyc_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      checkOutput("cyc_op", {1'b0, op}, {1'b0, e_op});
      checkOutput("cyc_illegal", {31'd0, illegal}, {31'd0, (m_valid && b < 0)});
      checkOutput("cyc_cnt8", {24'd0, illegal_cnt}, m_cnt8);
      checkOutput("cyc_cnt2", {30'd0, illegal_cnt2}, m_cnt2);
      checkOutput("cyc_out_valid2", {31'd0, out_valid2}, {31'd0, m_valid});
      if (m_valid) begin
        checkOutput("cyc_rs", {27'd0, rs}, {27'd0, m_instr[25:21]});
        checkOutput("cyc_rt", {27'd0, rt}, {27'd0, m_instr[20:16]});
        checkOutput("cyc_rd", {27'd0, rd}, {27'd0, m_instr[15:11]});
        checkOutput("cyc_shamt", {27'd0, shamt}, {27'd0, m_instr[10:6]});
        checkOutput("cyc_imm", imm_ext, model_imm(m_instr));
        checkOutput("cyc_target", {6'd0, target}, {6'd0, m_instr[25:0]});
        checkOutput("cyc_pc", out_pc, m_pc);
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl_instr [0:7];
  logic [30:0] tbl_op    [0:7];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;

    tbl_instr[0] = 32'h00000000; tbl_op[0] = 31'd1 << 8;
    tbl_instr[1] = 32'h03E00008; tbl_op[1] = 31'd1 << 30;
    tbl_instr[2] = 32'h3C01ABCD; tbl_op[2] = 31'd1 << 23;
    tbl_instr[3] = 32'hAC220008; tbl_op[3] = 31'd1 << 25;
    tbl_instr[4] = 32'h1022FFFE; tbl_op[4] = 31'd1 << 26;
    tbl_instr[5] = 32'h00021943; tbl_op[5] = 31'd1 << 10;
    tbl_instr[6] = 32'h2C22FFFF; tbl_op[6] = 31'd1 << 22;
    tbl_instr[7] = 32'h08000100; tbl_op[7] = 31'd1 << 28;

    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_op", {1'b0, op}, 32'd0);
    checkOutput("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    checkOutput("rst_pc", out_pc, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // addu $3,$1,$2
    applyStimulus(1'b1, 32'h00221821, 32'h100, 1'b1, 1'b0);
    checkOutput("addu_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("addu_op", {1'b0, op}, 32'h1);
    checkOutput("addu_rs", {27'd0, rs}, 32'd1);
    checkOutput("addu_rt", {27'd0, rt}, 32'd2);
    checkOutput("addu_rd", {27'd0, rd}, 32'd3);

    // andi zero-extends, addi sign-extends
    applyStimulus(1'b1, 32'h3022FFFF, 32'h104, 1'b1, 1'b0);
    checkOutput("andi_imm", imm_ext, 32'h0000FFFF);
    checkOutput("andi_op", {1'b0, op}, 32'h0004_0000);
    applyStimulus(1'b1, 32'h2022FFFF, 32'h108, 1'b1, 1'b0);
    checkOutput("addi_imm", imm_ext, 32'hFFFFFFFF);
    checkOutput("addi_op", {1'b0, op}, 32'h0001_0000);

    // ori at pc 0x40, then back-pressure for three cycles with xor waiting
    applyStimulus(1'b1, 32'h34221234, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h00221826, 32'h44, 1'b0, 1'b0);
      checkOutput("hold_pc", out_pc, 32'h40);
      checkOutput("hold_op", {1'b0, op}, 32'h0008_0000);
      checkOutput("hold_imm", imm_ext, 32'h00001234);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1'b1, 32'h00221826, 32'h44, 1'b1, 1'b0);
    checkOutput("bp_release_pc", out_pc, 32'h44);
    checkOutput("bp_release_op", {1'b0, op}, 32'h40);

    // Illegal encodings: opcode 0x3F, then R-type funct 0x3F, then three more
    applyStimulus(1'b1, 32'hFC000000, 32'h48, 1'b1, 1'b0);
    checkOutput("ill1_flag", {31'd0, illegal}, 32'd1);
    checkOutput("ill1_op", {1'b0, op}, 32'd0);
    checkOutput("ill1_cnt", {24'd0, illegal_cnt}, 32'd1);
    applyStimulus(1'b1, 32'h0000003F, 32'h4C, 1'b1, 1'b0);
    checkOutput("ill2_cnt", {24'd0, illegal_cnt}, 32'd2);
    applyStimulus(1'b1, 32'hFC000000, 32'h50, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000003F, 32'h54, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h7C000000, 32'h58, 1'b1, 1'b0);
    checkOutput("ill5_cnt8", {24'd0, illegal_cnt}, 32'd5);
    checkOutput("ill5_cnt2_sat", {30'd0, illegal_cnt2}, 32'd3);

    // jal held, then flush while lw is offered
    applyStimulus(1'b1, 32'h0C000010, 32'h80, 1'b1, 1'b0);
    checkOutput("jal_op", {1'b0, op}, 32'h2000_0000);
    applyStimulus(1'b0, 32'h0, 32'h84, 1'b0, 1'b0);
    in_valid  = 1'b1;
    in_instr  = 32'h8C220004;
    in_pc     = 32'h88;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'h8C220004, 32'h88, 1'b1, 1'b1);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_op", {1'b0, op}, 32'd0);
    checkOutput("flush_cnt", {24'd0, illegal_cnt}, 32'd5);
    // a flushed illegal word must not count
    applyStimulus(1'b1, 32'hFC000000, 32'h8C, 1'b1, 1'b1);
    checkOutput("flush_ill_cnt", {24'd0, illegal_cnt}, 32'd5);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back legal instructions, one per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, tbl_instr[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      checkOutput("tbl_op", {1'b0, op}, {1'b0, tbl_op[i]});
      checkOutput("tbl_illegal", {31'd0, illegal}, 32'd0);
    end
    checkOutput("j_target", {6'd0, target}, 32'h100);

    // Asynchronous reset between edges while full with a nonzero count
    rst_n = 1'b0;
    #2;
    checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    checkOutput("async_rst_op", {1'b0, op}, 32'd0);
    #4;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00221821, 32'h300, 1'b1, 1'b0);
    checkOutput("post_rst_op", {1'b0, op}, 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
